// File: rtl/rv32i_pkg.sv
// Shared fetch-path definitions: datapath width, reset vector, fetch FSM states
// and the {pc, inst} entry carried through the fetch buffer.
package rv32i_pkg;
   localparam int                   DataWidth = 32;
   localparam logic [DataWidth-1:0] ResetPc   = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FULL  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [DataWidth-1:0] pc;
      logic [DataWidth-1:0] inst;
   } fetch_entry_t;

   // Branch targets carry no meaningful byte offset; fetch is always word-aligned.
   function automatic logic [DataWidth-1:0] word_align(input logic [DataWidth-1:0] addr);
      return addr & ~DataWidth'(3);
   endfunction
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, inst} pairs between instruction memory and decode.
// Flush empties it in one cycle; push is ignored when full, pop when empty.
module fetch_buffer
   import rv32i_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wr_entry,
   output fetch_entry_t rd_entry,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);
   fetch_entry_t r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         w_push_ok;
   logic         w_pop_ok;

   assign full      = (r_count == 2'd2);
   assign empty     = (r_count == 2'd0);
   assign count     = r_count;
   assign rd_entry  = r_mem[r_rd_ptr];
   assign w_push_ok = push && !full;
   assign w_pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_entry;
            r_wr_ptr        <= !r_wr_ptr;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= !r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
      end
   end
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequential PC fetch with one outstanding memory request,
// a 2-entry output buffer toward decode, and redirect (flush + drop) handling.
//
// state    | meaning
// ST_FETCH | request offered to memory (when buffer has room and no redirect)
// ST_WAIT  | one request accepted, response pending (r_drop: discard it)
// ST_FULL  | buffer holds two entries, waiting for decode to pop
module instruction_fetch #(
   parameter int                   DataWidth = rv32i_pkg::DataWidth,
   parameter logic [DataWidth-1:0] ResetPc   = rv32i_pkg::ResetPc
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [DataWidth-1:0] imem_addr,
   input  logic                 imem_rsp_valid,
   input  logic [DataWidth-1:0] imem_rsp_data,
   input  logic                 redirect_valid,
   input  logic [DataWidth-1:0] redirect_pc,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic [DataWidth-1:0] inst,
   output logic [DataWidth-1:0] inst_pc
);
   import rv32i_pkg::*;

   fetch_state_e         r_state;
   fetch_state_e         w_state_nxt;
   logic [DataWidth-1:0] r_pc;
   logic [DataWidth-1:0] w_pc_nxt;
   logic [DataWidth-1:0] r_req_pc;
   logic                 r_drop;
   logic                 w_drop_nxt;
   logic                 w_transfer;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_rsp_in_wait;
   logic                 w_space_after;
   logic                 w_full;
   logic                 w_empty;
   logic [1:0]           w_count;
   fetch_entry_t         w_push_entry;
   fetch_entry_t         w_head;

   // Outputs are forced to reset values combinationally while rst is low.
   assign imem_req_valid = rst && (r_state == ST_FETCH) && !w_full && !redirect_valid;
   assign imem_addr      = rst ? r_pc : ResetPc;
   assign inst_valid     = rst && !w_empty && !redirect_valid;
   assign inst           = rst ? w_head.inst : '0;
   assign inst_pc        = rst ? w_head.pc : '0;

   assign w_transfer    = imem_req_valid && imem_req_ready;
   assign w_pop         = inst_valid && inst_ready;
   assign w_rsp_in_wait = (r_state == ST_WAIT) && imem_rsp_valid;
   assign w_push        = w_rsp_in_wait && !r_drop && !redirect_valid;
   // WAIT is only entered with at most one entry buffered.
   assign w_space_after = (w_count == 2'd0) || w_pop;
   assign w_push_entry  = '{pc: r_req_pc, inst: imem_rsp_data};

   fetch_buffer u_fetch_buffer (
      .clk      (clk),
      .rst      (rst),
      .push     (w_push),
      .pop      (w_pop),
      .flush    (redirect_valid),
      .wr_entry (w_push_entry),
      .rd_entry (w_head),
      .full     (w_full),
      .empty    (w_empty),
      .count    (w_count)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_drop_nxt  = r_drop;
      if (redirect_valid) begin
         w_pc_nxt = word_align(redirect_pc);
         // A request still in flight must have its response discarded.
         if ((r_state == ST_WAIT) && !imem_rsp_valid) begin
            w_state_nxt = ST_WAIT;
            w_drop_nxt  = 1'b1;
         end else begin
            w_state_nxt = ST_FETCH;
            w_drop_nxt  = 1'b0;
         end
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_transfer) begin
                  w_state_nxt = ST_WAIT;
                  w_pc_nxt    = r_pc + DataWidth'(4);
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = (r_drop || w_space_after) ? ST_FETCH : ST_FULL;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  w_state_nxt = ST_FETCH;
               end
            end
            default: w_state_nxt = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_FETCH;
         r_pc     <= ResetPc;
         r_req_pc <= ResetPc;
         r_drop   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_drop  <= w_drop_nxt;
         if (w_transfer) begin
            r_req_pc <= r_pc;
         end
      end
   end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a memory model and random driver feed a transaction-level
// model of the expected instruction stream; a monitor pops and compares every delivery.
module tb_instruction_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   instruction_fetch #(.DataWidth(32), .ResetPc(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          pops = 0;
   int          occ_start = 0;
   logic [31:0] q_pc[$];
   logic [31:0] q_word[$];
   logic [31:0] fetch_pc;
   bit          outstanding;
   bit          out_stale;
   logic [31:0] out_addr;
   logic [31:0] out_pc;
   int          out_timer;
   int          p_req_ready, p_inst_ready, p_redir, lat_min, lat_max;
   bit          prev_req_hold = 1'b0;
   logic [31:0] prev_req_addr = '0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_inst = '0;
   logic [31:0] prev_ipc = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] rand_target();
      int unsigned sel = $urandom_range(3);
      if (sel == 0) return 32'hFFFF_FFE0 | 32'($urandom_range(31));
      return 32'($urandom_range(32'h0000_0FFF));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: FIFO visibility, hold stability and in-order delivery against the queue.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         occ_start = q_pc.size();
         chk("inst_valid", 32'(inst_valid), 32'(rst && !redirect_valid && (q_pc.size() > 0)));
         if (prev_hold && rst && !redirect_valid) begin
            chk("hold_inst", inst, prev_inst);
            chk("hold_inst_pc", inst_pc, prev_ipc);
         end
         if (rst && inst_valid && inst_ready) begin
            total++;
            if (q_pc.size() == 0) begin
               bad++;
               $display("FAIL pop_unexpected: got inst_pc %h with nothing expected", inst_pc);
            end else begin
               total--;
               chk("inst_pc", inst_pc, q_pc.pop_front());
               chk("inst_word", inst, q_word.pop_front());
               pops++;
            end
         end
         prev_hold = rst && inst_valid && !inst_ready;
         prev_inst = inst;
         prev_ipc  = inst_pc;
      end
   end

   // One cycle of stimulus plus the memory/stream model update.
   task automatic step(input bit force_redir, input logic [31:0] tgt, input bit do_rst, input bit junk);
      bit respond;
      bit redir;
      @(negedge clk);
      rst            = !do_rst;
      respond        = outstanding && (out_timer == 0);
      imem_rsp_valid = respond || junk;
      imem_rsp_data  = respond ? mem_word(out_addr) : $urandom;
      imem_req_ready = ($urandom_range(99) < p_req_ready);
      inst_ready     = ($urandom_range(99) < p_inst_ready);
      redir          = force_redir || (!do_rst && ($urandom_range(999) < p_redir));
      redirect_valid = redir;
      redirect_pc    = force_redir ? tgt : rand_target();
      #2;
      if (do_rst) begin
         chk("rst_addr", imem_addr, RESET_PC);
         chk("rst_inst", inst, 32'h0);
         chk("rst_inst_pc", inst_pc, 32'h0);
      end
      chk("req_valid", 32'(imem_req_valid), 32'(!do_rst && !redir && !outstanding && (occ_start < 2)));
      if (prev_req_hold && imem_req_valid) chk("req_addr_hold", imem_addr, prev_req_addr);
      prev_req_hold = imem_req_valid && !imem_req_ready;
      prev_req_addr = imem_addr;
      if (respond) begin
         if (!out_stale && !redir && !do_rst) begin
            q_pc.push_back(out_pc);
            q_word.push_back(mem_word(out_pc));
         end
         outstanding = 1'b0;
      end
      if (do_rst) begin
         q_pc.delete();
         q_word.delete();
         outstanding = 1'b0;
         fetch_pc    = RESET_PC;
      end else if (redir) begin
         q_pc.delete();
         q_word.delete();
         fetch_pc = redirect_pc & ~32'd3;
         if (outstanding) out_stale = 1'b1;
      end
      if (imem_req_valid && imem_req_ready) begin
         chk("fetch_addr", imem_addr, fetch_pc);
         outstanding = 1'b1;
         out_stale   = 1'b0;
         out_addr    = imem_addr;
         out_pc      = fetch_pc;
         out_timer   = int'($urandom_range(lat_max, lat_min)) - 1;
         fetch_pc    = fetch_pc + 32'd4;
      end else if (outstanding && (out_timer > 0)) begin
         out_timer--;
      end
   endtask

   initial begin
      int n;
      rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      fetch_pc = RESET_PC; outstanding = 1'b0; out_stale = 1'b0; out_addr = '0; out_pc = '0; out_timer = 0;
      p_req_ready = 100; p_inst_ready = 100; p_redir = 0; lat_min = 1; lat_max = 1;

      // Reset with stray responses, then the first released cycle must fetch ResetPc.
      step(0, 0, 1, 0);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
      repeat (12) step(0, 0, 0, 0);
      chk("startup_deliveries", 32'(pops >= 3), 32'd1);

      // Decode stall: buffer fills to two, requests stop, head held.
      p_inst_ready = 0;
      repeat (10) step(0, 0, 0, 0);
      chk("stall_inst_valid", 32'(inst_valid), 32'd1);
      chk("stall_no_req", 32'(imem_req_valid), 32'd0);
      p_inst_ready = 100;
      repeat (10) step(0, 0, 0, 0);

      // Redirect to a misaligned target while a request is outstanding.
      lat_min = 3; lat_max = 3;
      n = 0;
      while (!(outstanding && out_timer > 0) && n < 20) begin step(0, 0, 0, 0); n++; end
      chk("wait_for_outstanding_a", 32'(n < 20), 32'd1);
      step(1, 32'h0000_0103, 0, 0);
      repeat (12) step(0, 0, 0, 0);

      // Redirect coinciding with a response while the buffer holds an entry.
      lat_min = 2; lat_max = 2; p_inst_ready = 0;
      n = 0;
      while (!(q_pc.size() == 1 && outstanding && out_timer == 0 && !out_stale) && n < 30) begin
         step(0, 0, 0, 0); n++;
      end
      chk("wait_for_rsp_with_entry", 32'(n < 30), 32'd1);
      step(1, 32'h0000_0200, 0, 0);
      p_inst_ready = 100;
      repeat (10) step(0, 0, 0, 0);

      // PC wrap across the top of the address space.
      lat_min = 1; lat_max = 1;
      step(1, 32'hFFFF_FFF8, 0, 0);
      repeat (14) step(0, 0, 0, 0);

      // Reset in the middle of an outstanding request; late responses ignored.
      lat_min = 3; lat_max = 3;
      n = 0;
      while (!(outstanding && out_timer > 0) && n < 20) begin step(0, 0, 0, 0); n++; end
      chk("wait_for_outstanding_b", 32'(n < 20), 32'd1);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
      repeat (12) step(0, 0, 0, 0);

      // Randomized traffic.
      p_req_ready = 70; p_inst_ready = 60; p_redir = 30; lat_min = 1; lat_max = 4;
      repeat (4000) step(0, 0, 0, 0);
      p_inst_ready = 20; p_redir = 80;
      repeat (1000) step(0, 0, 0, 0);

      // Drain everything still in flight.
      p_req_ready = 0; p_inst_ready = 100; p_redir = 0;
      n = 0;
      while ((outstanding || q_pc.size() > 0) && n < 50) begin step(0, 0, 0, 0); n++; end
      chk("drain_done", 32'(n < 50), 32'd1);
      step(0, 0, 0, 0);
      chk("total_deliveries", 32'(pops > 500), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
